data_sram_arbiter: RTL

- Shares the single-port data SRAM between two requesters:
  - port 0: the pipeline exe-stage load/store path.
  - port 1: a secondary master, e.g. a debug or DMA engine.
- Arbitrates round-robin (or fixed priority) with valid/ready request handshakes.
- Tracks the 1-cycle SRAM read latency and routes read data back to the issuing port through a per-port holding register with valid/ready.
- Sits between the requesters and the data_sram_* pins.

---
 rtl/data_sram_arbiter_pkg.sv | 11 +
 rtl/data_sram_arbiter_arb_rr2.sv | 27 ++
 rtl/data_sram_arbiter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/data_sram_arbiter_pkg.sv
// Shared definitions for the data SRAM arbiter: width defaults and port indices.
package data_sram_arbiter_pkg;

  localparam int ARB_ADDR_W_DEF = 32;
  localparam int ARB_DATA_W_DEF = 32;

  // Requester indices into the per-port vectors.
  localparam int ARB_P0 = 0;
  localparam int ARB_P1 = 1;

endpackage

// File: rtl/data_sram_arbiter_arb_rr2.sv
// Two-way arbiter: round-robin on ties, or fixed priority to port 0.
// Purely combinational; the last-grant history is stored by the parent.
module arb_rr2
  import data_sram_arbiter_pkg::*;
#(
  parameter int PRIO_FIXED = 0
) (
  input  logic [1:0] eligible,
  input  logic       last_grant,
  output logic [1:0] grant
);

  // Pick at most one eligible port. On a round-robin tie, the port that was not granted last wins.
  always_comb begin
    grant = 2'b00;
    if (PRIO_FIXED != 0) begin
      grant[ARB_P0] = eligible[ARB_P0];
      grant[ARB_P1] = eligible[ARB_P1] && !eligible[ARB_P0];
    end else if (eligible[ARB_P0] && eligible[ARB_P1]) begin
      if (last_grant) grant[ARB_P0] = 1'b1;
      else            grant[ARB_P1] = 1'b1;
    end else begin
      grant = eligible;
    end
  end

endmodule

// File: rtl/data_sram_arbiter.sv
// Shares the single-port data SRAM between the exe-stage load/store path
// (port 0) and a secondary master (port 1). Read data returns one cycle
// after the SRAM enable and is parked in a per-port holding register.
module data_sram_arbiter
  import data_sram_arbiter_pkg::*;
#(
  parameter int ADDR_W     = ARB_ADDR_W_DEF,
  parameter int DATA_W     = ARB_DATA_W_DEF,
  parameter int PRIO_FIXED = 0
) (
  input  logic                clk,
  input  logic                resetn,
  // port 0
  input  logic                m0_req_valid,
  output logic                m0_req_ready,
  input  logic [DATA_W/8-1:0] m0_req_we,
  input  logic [ADDR_W-1:0]   m0_req_addr,
  input  logic [DATA_W-1:0]   m0_req_wdata,
  output logic                m0_rsp_valid,
  input  logic                m0_rsp_ready,
  output logic [DATA_W-1:0]   m0_rsp_rdata,
  // port 1
  input  logic                m1_req_valid,
  output logic                m1_req_ready,
  input  logic [DATA_W/8-1:0] m1_req_we,
  input  logic [ADDR_W-1:0]   m1_req_addr,
  input  logic [DATA_W-1:0]   m1_req_wdata,
  output logic                m1_rsp_valid,
  input  logic                m1_rsp_ready,
  output logic [DATA_W-1:0]   m1_rsp_rdata,
  // SRAM pins
  output logic                data_sram_en,
  output logic [DATA_W/8-1:0] data_sram_we,
  output logic [ADDR_W-1:0]   data_sram_addr,
  output logic [DATA_W-1:0]   data_sram_wdata,
  input  logic [DATA_W-1:0]   data_sram_rdata
);

  localparam int BE_W = DATA_W / 8;

  logic [1:0]        req_valid;
  logic [1:0]        rsp_ready;
  logic [BE_W-1:0]   req_we    [2];
  logic [ADDR_W-1:0] req_addr  [2];
  logic [DATA_W-1:0] req_wdata [2];
  logic [1:0]        inflight;
  logic [1:0]        rsp_vld;
  logic [DATA_W-1:0] rsp_rdata [2];
  logic [1:0]        eligible;
  logic [1:0]        grant;
  logic              last_grant;

  assign req_valid[ARB_P0] = m0_req_valid;
  assign req_valid[ARB_P1] = m1_req_valid;
  assign rsp_ready[ARB_P0] = m0_rsp_ready;
  assign rsp_ready[ARB_P1] = m1_rsp_ready;
  assign req_we[ARB_P0]    = m0_req_we;
  assign req_we[ARB_P1]    = m1_req_we;
  assign req_addr[ARB_P0]  = m0_req_addr;
  assign req_addr[ARB_P1]  = m1_req_addr;
  assign req_wdata[ARB_P0] = m0_req_wdata;
  assign req_wdata[ARB_P1] = m1_req_wdata;

  // A port may be granted only when it has no read in flight and its
  // holding register is empty or draining this cycle.
  assign eligible = req_valid & ~inflight & (~rsp_vld | rsp_ready);

  arb_rr2 #(
    .PRIO_FIXED (PRIO_FIXED)
  ) u_arb (
    .eligible   (eligible),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign m0_req_ready = grant[ARB_P0];
  assign m1_req_ready = grant[ARB_P1];

  // Remember who won most recently; reset favours port 0 on the first tie.
  always_ff @(posedge clk) begin
    if (!resetn)    last_grant <= 1'b1;
    else if (|grant) last_grant <= grant[ARB_P1];
  end

  // Drive the SRAM straight from the granted port, all-zero when idle.
  always_comb begin
    data_sram_en    = 1'b0;
    data_sram_we    = '0;
    data_sram_addr  = '0;
    data_sram_wdata = '0;
    if (grant[ARB_P0]) begin
      data_sram_en    = 1'b1;
      data_sram_we    = req_we[ARB_P0];
      data_sram_addr  = req_addr[ARB_P0];
      data_sram_wdata = req_wdata[ARB_P0];
    end else if (grant[ARB_P1]) begin
      data_sram_en    = 1'b1;
      data_sram_we    = req_we[ARB_P1];
      data_sram_addr  = req_addr[ARB_P1];
      data_sram_wdata = req_wdata[ARB_P1];
    end
  end

  for (genvar i = 0; i < 2; i++) begin : g_rsp
    logic              inflight_p1;
    logic              rsp_vld_p2;
    logic [DATA_W-1:0] rsp_rdata_p2;

    // Stage p1: read issued last cycle; stage p2: data parked until taken.
    // A fresh capture overrides the drain so a back-to-back read is never lost.
    always_ff @(posedge clk) begin
      if (!resetn) begin
        inflight_p1  <= 1'b0;
        rsp_vld_p2   <= 1'b0;
        rsp_rdata_p2 <= '0;
      end else begin
        inflight_p1 <= grant[i] && (req_we[i] == '0);
        if (inflight_p1) begin
          rsp_vld_p2   <= 1'b1;
          rsp_rdata_p2 <= data_sram_rdata;
        end else if (rsp_ready[i]) begin
          rsp_vld_p2 <= 1'b0;
        end
      end
    end

    assign inflight[i]  = inflight_p1;
    assign rsp_vld[i]   = rsp_vld_p2;
    assign rsp_rdata[i] = rsp_rdata_p2;
  end

  assign m0_rsp_valid = rsp_vld[ARB_P0];
  assign m0_rsp_rdata = rsp_rdata[ARB_P0];
  assign m1_rsp_valid = rsp_vld[ARB_P1];
  assign m1_rsp_rdata = rsp_rdata[ARB_P1];

endmodule
